// File: rtl/prng_share_ctrl_pkg.sv
// Shared types and default parameters for the PRNG sharing controller.
package prng_ctrl_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WARM  = 2'd1,
        SERVE = 2'd2
    } state_e;

    localparam int         DEF_NUM_REQ  = 4;
    localparam int         DEF_WIDTH    = 8;
    localparam int         DEF_WARMUP   = 16;
    localparam logic [7:0] DEFAULT_SEED = 8'hA5;

endpackage

// File: rtl/prng_share_ctrl_if.sv
// Requester-side bus: level requests and reseed in, grant pulse and word out.
interface prng_share_ctrl_if
    import prng_ctrl_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [WIDTH-1:0]   rnd_out;
    logic               seed_load;
    logic [WIDTH-1:0]   seed_in;

    // consumers / wrapper side
    modport master (output req, seed_load, seed_in, input gnt, rnd_out);
    // controller side
    modport slave  (input req, seed_load, seed_in, output gnt, rnd_out);
endinterface

// File: rtl/prng_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
    import prng_ctrl_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int PW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt_next,
    output logic [PW-1:0]      winner,
    output logic               any
);

    int j;

    // scan from the pointer; the first hit wins and later hits are ignored
    always_comb begin
        gnt_next = '0;
        winner   = '0;
        any      = 1'b0;
        j        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any && req[j]) begin
                any         = 1'b1;
                winner      = PW'(j);
                gnt_next[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prng_share_ctrl.sv
// Seeds and warms up the PRNG core, then shares it round-robin so each
// grant carries a word that no other grant has seen.
module prng_share_ctrl
    import prng_ctrl_pkg::*;
#(
    parameter int NUM_REQ                  = DEF_NUM_REQ,
    parameter int WIDTH                    = DEF_WIDTH,
    parameter int WARMUP                   = DEF_WARMUP,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(prng_ctrl_pkg::DEFAULT_SEED)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    prng_share_ctrl_if.slave     bus,
    output logic                 prng_load,
    output logic [WIDTH-1:0]     prng_seed,
    output logic                 prng_step,
    input  logic [WIDTH-1:0]     prng_data,
    output logic                 busy
);

    localparam int CW = $clog2(WARMUP + 1);
    localparam int PW = $clog2(NUM_REQ);

    state_e             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [PW-1:0]      ptr;
    logic [WIDTH-1:0]   seed_reg;
    logic [NUM_REQ-1:0] gnt_r;
    logic [WIDTH-1:0]   rnd_r;
    logic               fire;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [PW-1:0]      arb_idx;
    logic               arb_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req      (bus.req),
        .ptr      (ptr),
        .gnt_next (arb_gnt),
        .winner   (arb_idx),
        .any      (arb_any)
    );

    // state register; reset always returns to LOAD
    always_ff @(posedge clk) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    // next state and core strobes; ena low freezes everything
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        prng_load = 1'b0;
        prng_step = 1'b0;
        fire      = 1'b0;
        if (ena) begin
            case (state)
                LOAD: begin
                    prng_load = 1'b1;
                    state_nxt = WARM;
                    cnt_nxt   = '0;
                end
                WARM: begin
                    prng_step = 1'b1;
                    if (cnt == CW'(WARMUP - 1)) state_nxt = SERVE;
                    else                        cnt_nxt   = cnt + 1'b1;
                end
                SERVE: begin
                    // stepping on every grant keeps words from being reused
                    fire      = arb_any && !bus.seed_load;
                    prng_step = fire;
                end
                default: state_nxt = LOAD;
            endcase
            // a reseed overrides whatever the current state wanted
            if (bus.seed_load) state_nxt = LOAD;
        end
    end

    // seed, warm counter, pointer and registered grant/word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seed_reg <= DEFAULT_SEED;
            cnt      <= '0;
            ptr      <= '0;
            gnt_r    <= '0;
            rnd_r    <= '0;
        end else if (ena) begin
            cnt <= cnt_nxt;
            if (bus.seed_load) begin
                seed_reg <= (bus.seed_in == '0) ? DEFAULT_SEED : bus.seed_in;
                gnt_r    <= '0;
            end else if (fire) begin
                gnt_r <= arb_gnt;
                rnd_r <= prng_data;
                ptr   <= (arb_idx == PW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            end else begin
                gnt_r <= '0;
            end
        end else begin
            gnt_r <= '0;
        end
    end

    assign prng_seed   = seed_reg;
    assign busy        = (state != SERVE);
    assign bus.gnt     = gnt_r;
    assign bus.rnd_out = rnd_r;

endmodule

// File: tb/tb_prng_share_ctrl.sv
// Randomized bench for prng_share_ctrl with a transaction-level reference:
// the k-th grant after a (re)seed must carry LFSR^(WARMUP+k)(seed).
module tb_prng_share_ctrl;
    import prng_ctrl_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int WU = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, ena;
    logic         prng_load, prng_step, busy;
    logic [W-1:0] prng_seed, prng_data;

    prng_share_ctrl_if #(.NUM_REQ(N), .WIDTH(W)) bus();

    prng_share_ctrl #(.NUM_REQ(N), .WIDTH(W), .WARMUP(WU)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .bus       (bus),
        .prng_load (prng_load),
        .prng_seed (prng_seed),
        .prng_step (prng_step),
        .prng_data (prng_data),
        .busy      (busy)
    );

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] x);
        return {x[W-2:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    function automatic logic [W-1:0] lfsr_n(input logic [W-1:0] s, input int n);
        logic [W-1:0] x;
        x = s;
        for (int i = 0; i < n; i++) x = lfsr_step(x);
        return x;
    endfunction

    // stand-in for the PRNG core register
    logic [W-1:0] core = '0;
    always @(posedge clk) begin
        if (prng_load)      core <= prng_seed;
        else if (prng_step) core <= lfsr_step(core);
    end
    assign prng_data = core;

    // reference model state
    bit           m_init = 1'b0;
    int           m_since, m_grants, m_ptr;
    logic [W-1:0] m_seed, m_rnd;
    logic [N-1:0] m_gnt;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int w;
        w = -1;
        if (!rst_n) begin
            m_init = 1'b1; m_since = 0; m_seed = 8'hA5; m_ptr = 0;
            m_gnt = '0; m_rnd = '0; m_grants = 0;
        end else if (!m_init) begin
            m_gnt = m_gnt;
        end else if (!ena) begin
            m_gnt = '0;
        end else if (bus.seed_load) begin
            m_seed   = (bus.seed_in == 0) ? 8'hA5 : bus.seed_in;
            m_since  = 0;
            m_grants = 0;
            m_gnt    = '0;
        end else if (m_since > WU) begin
            if (bus.req != 0) begin
                for (int k = 0; k < N; k++)
                    if (w < 0 && bus.req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                m_gnt    = '0;
                m_gnt[w] = 1'b1;
                m_rnd    = lfsr_n(m_seed, WU + m_grants);
                m_grants++;
                m_ptr    = (w + 1) % N;
            end else begin
                m_gnt = '0;
            end
        end else begin
            m_since++;
            m_gnt = '0;
        end
    endtask

    // one clock: check outputs at negedge, advance model at the edge
    task automatic step();
        @(negedge clk);
        if (m_init && rst_n) begin
            chk("busy", busy, m_since <= WU);
            chk("prng_load", prng_load, ena && m_since == 0);
            chk("prng_step", prng_step,
                ena && ((m_since >= 1 && m_since <= WU) ||
                        (m_since > WU && bus.req != 0 && !bus.seed_load)));
            if (ena && m_since == 0) chk("prng_seed", prng_seed, m_seed);
        end
        if (m_init) begin
            chk("gnt", bus.gnt, m_gnt);
            chk("rnd_out", bus.rnd_out, m_rnd);
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        int cnt;
        logic [W-1:0] prev;
        rst_n = 1'b0; ena = 1'b1;
        bus.req = '0; bus.seed_load = 1'b0; bus.seed_in = '0;
        step(); step();
        rst_n = 1'b1;

        // reset release, idle through LOAD and warm-up
        for (int i = 0; i < 20; i++) step();

        // all requesters held: strict rotation, fresh words
        bus.req = 4'b1111;
        prev = bus.rnd_out;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_seq", bus.gnt, 32'(1) << (i % 4));
            chk("fresh", 32'(bus.rnd_out != prev), 1);
            prev = bus.rnd_out;
        end

        // sole requester granted every cycle
        bus.req = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("sole", bus.gnt, 4'b0100);
        end

        // zero seed while serving: suppressed grant, default seed reload
        bus.req = 4'b1111; bus.seed_in = '0; bus.seed_load = 1'b1;
        step();
        bus.seed_load = 1'b0;
        chk("seed_gnt", bus.gnt, 0);
        for (int i = 0; i < 8; i++) step();   // LOAD + 7 warm steps
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("ena_gnt", bus.gnt, 0);
        end
        ena = 1'b1;
        cnt = 0;
        while (busy && cnt < 40) begin
            step();
            cnt++;
        end
        chk("warm_len", cnt, 9);
        step();
        chk("ptr_kept", bus.gnt, 4'b1000);

        // randomized traffic with occasional disable, reseed and reset
        for (int i = 0; i < 400; i++) begin
            rst_n         = ($urandom_range(99) != 0);
            ena           = ($urandom_range(9) != 0);
            bus.seed_load = ($urandom_range(29) == 0);
            bus.seed_in   = ($urandom_range(3) == 0) ? '0 : W'($urandom);
            bus.req       = N'($urandom);
            step();
        end

        // reset mid-serve: pending grant dropped, rotation restarts at 0
        rst_n = 1'b1; ena = 1'b1; bus.seed_load = 1'b0; bus.req = 4'b1111;
        cnt = 0;
        while (busy && cnt < 60) begin
            step();
            cnt++;
        end
        chk("serve_reached", busy, 0);
        step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_gnt", bus.gnt, 0);
        cnt = 0;
        while (busy && cnt < 40) begin
            step();
            cnt++;
        end
        chk("rst_warm", cnt, 17);
        step();
        chk("post_rst_first", bus.gnt, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prng_share_ctrl.md
Name: prng_share_ctrl

Overview:
- Controller between the PRNG core (tt_um_jduchniewicz_prng datapath: LFSR state, load/step controls) and NUM_REQ on-chip consumers.
- Sequences seeding and warm-up, then shares the generator round-robin so that every grant delivers a fresh, never-reused word.
- Sits in the top-level wrapper. Requesters see a request/grant pulse interface; the core sees only load/step strobes.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, random word / seed width.
- WARMUP, 16, discarded steps after every (re)seed (>=1).
- DEFAULT_SEED, 8'hA5, seed used after reset and in place of a zero seed.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Synchronous, active-low.
- ena  in  1  design enable. Low freezes all state.
- req  in  NUM_REQ  per-requester level request.
- gnt  out  NUM_REQ  one-hot grant pulse; rnd_out is valid when any bit is set.
- rnd_out  out  WIDTH  random word for the granted requester.
- seed_load  in  1  single-cycle pulse: reseed with seed_in.
- seed_in  in  WIDTH  new seed, sampled when seed_load=1.
- prng_load  out  1  core loads prng_seed on the next edge. Has priority over step.
- prng_seed  out  WIDTH  seed presented to the core.
- prng_step  out  1  core advances one state on the next edge.
- prng_data  in  WIDTH  current core state (combinational from core register).
- busy  out  1  high whenever state != SERVE.

Behaviour:
- Reset (rst_n=0 at an edge, any state):
  - state=LOAD, seed_reg=DEFAULT_SEED, rr pointer=0, warm counter=0.
  - gnt=0, rnd_out=0, busy=1.
  - Reset mid-operation discards any pending grant.
- FSM LOAD: prng_load=1, prng_seed=seed_reg, prng_step=0. Next state WARM, counter cleared.
- FSM WARM:
  - prng_step=1 each cycle; counter increments.
  - After WARMUP step cycles, go to SERVE.
  - From reset release: cycle 0 is LOAD, cycles 1..16 are WARM, first SERVE cycle is 17.
- FSM SERVE:
  - If any req bit is set, choose the first set bit at or after the pointer (wrapping modulo NUM_REQ).
  - Next edge: gnt=onehot(winner), rnd_out=prng_data sampled that cycle; prng_step=1 in the same cycle, so the next grant sees a new word. Pointer becomes winner+1 (wraps from NUM_REQ-1 to 0).
  - No req: gnt=0, rnd_out holds its last value, prng_step=0.
- Latency: req high at cycle t -> gnt at t+1.
- Grant rules:
  - gnt is a 1-cycle pulse.
  - A held req is re-granted only when its turn comes again.
  - Worst-case wait is NUM_REQ cycles.
  - A sole requester is granted every cycle.
- seed_load:
  - Sampled in any state: seed_reg <= (seed_in==0) ? DEFAULT_SEED : seed_in; state -> LOAD.
  - Same-cycle grant is suppressed (gnt=0 next cycle); the pointer is kept.
  - seed_load during LOAD or WARM restarts the sequence.
  - seed_load in the same cycle as requests: seed wins.
- ena=0: state, counter, pointer and seed_reg hold; gnt=0; prng_load=prng_step=0; seed_load is ignored. Reset still acts.
- busy: combinational from state.
- Widths:
  - Warm counter is $clog2(WARMUP+1) bits.
  - Pointer is $clog2(NUM_REQ) bits, with explicit wrap at NUM_REQ for non-power-of-2 values.

Decomposition:
- Package prng_ctrl_pkg:
  - state enum {LOAD, WARM, SERVE};
  - DEFAULT_SEED;
  - defaults for NUM_REQ, WIDTH, WARMUP.
- Sub-module rr_arbiter:
  - parameter NUM_REQ;
  - inputs req, ptr;
  - outputs onehot gnt_next, winner index, any.
  - Purely combinational. The pointer register lives in the parent.

Test Plan:
- Reset then idle:
  - prng_load=1 at cycle 0 with prng_seed=8'hA5.
  - prng_step=1 for cycles 1..16.
  - busy falls at cycle 17; gnt=0 throughout.
- All four req held from cycle 17:
  - gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
  - Each rnd_out equals the model LFSR word, with no repeats across consecutive grants.
- req=0100 only, pointer at 0: gnt=0100 next cycle and then every cycle; prng_step=1 each cycle.
- seed_load=1 with seed_in=8'h00 while serving:
  - next cycle gnt=0, prng_load=1, prng_seed=8'hA5;
  - 16 warm cycles follow, then grants resume with the pointer preserved.
- ena=0 for 5 cycles mid-WARM (counter=7), then ena=1: warm ends exactly 9 enabled cycles later; no gnt or step while ena=0.
- rst_n=0 for one edge mid-SERVE with req=1111: gnt=0 next cycle and LOAD is re-entered. The first post-reset grant after warm-up goes to requester 0 (gnt=0001).
